// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// ----------------------------------------------------------------------------
// Pipeline interlock controller for the 5-stage MIPS core. It sits beside the
// ID stage and decides each cycle whether the ID instruction may advance.
// Three hazard sources are covered:
//   - load-use: the EX instruction is a load writing a register that ID reads
//   - branch compare in ID: a branch needs its operands in ID, so it waits for
//     an EX writer (ALU or load) and for a load still in MEM
//   - multiply/divide unit: MDU ops and HI/LO accesses wait while it is busy
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   id_rs, id_rt, id_use_rs/rt    ID source registers and their use flags
//   id_is_branch                  ID instruction compares registers in ID
//   id_is_mdu, id_mdu_div         ID is MULT/MULTU/DIV/DIVU (div = 1)
//   id_is_hilo                    ID is MFHI/MFLO/MTHI/MTLO
//   ex_wreg, ex_is_load, ex_rd    EX stage writer description
//   mem_wreg, mem_is_load, mem_rd MEM stage writer description
//   stall, pc_en, if_id_en,       interlock controls (zero latency, derived
//   id_ex_flush                   combinationally from inputs and state)
//   mdu_start                     one-cycle MDU start pulse
//   mdu_op                        operation of the running MDU op (1 = divide)
//   mdu_busy, mdu_done            counter nonzero / last busy cycle
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_is_branch,
    input  logic       id_is_mdu,
    input  logic       id_mdu_div,
    input  logic       id_is_hilo,
    input  logic       ex_wreg,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    input  logic       mem_wreg,
    input  logic       mem_is_load,
    input  logic [4:0] mem_rd,
    output logic       stall,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       id_ex_flush,
    output logic       mdu_start,
    output logic       mdu_op,
    output logic       mdu_busy,
    output logic       mdu_done
);

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    mdu_state_e state_q, state_d;
    logic [5:0] count_q, count_d;
    logic       mdu_op_q, mdu_op_d;

    logic hit_ex_s;
    logic hit_mem_s;
    logic lu_s;
    logic br_s;
    logic mc_s;
    logic stall_s;
    logic start_s;

    // Hazard detection: register $0 is never a real destination, so it is masked.
    always_comb begin
        hit_ex_s  = ex_wreg & (ex_rd != 5'd0) &
                    ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
        hit_mem_s = mem_wreg & (mem_rd != 5'd0) &
                    ((id_use_rs & (id_rs == mem_rd)) | (id_use_rt & (id_rt == mem_rd)));
        lu_s      = hit_ex_s & ex_is_load;
        // An ALU result in MEM is forwarded into ID; only a MEM load still blocks.
        br_s      = id_is_branch & (hit_ex_s | (hit_mem_s & mem_is_load));
        mc_s      = (id_is_mdu | id_is_hilo) & (count_q != 6'd0);
        stall_s   = lu_s | br_s | mc_s;
        // Any stall suppresses the start, so a held MDU op never launches twice.
        start_s   = id_is_mdu & ~stall_s & ~rst;
    end

    // MDU sequencer next-state: load on start, count down, release at count 1.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mdu_op_d = mdu_op_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d  = ST_BUSY;
                    count_d  = id_mdu_div ? DIV_LOAD : MUL_LOAD;
                    mdu_op_d = id_mdu_div;
                end else begin
                    count_d  = 6'd0;
                end
            end
            ST_BUSY: begin
                // count 0 in BUSY cannot happen normally; treating it like the
                // last cycle keeps the counter from wrapping.
                if (count_q <= 6'd1) begin
                    state_d = ST_IDLE;
                    count_d = 6'd0;
                end else begin
                    count_d = count_q - 6'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                count_d  = 6'd0;
                mdu_op_d = 1'b0;
            end
        endcase
    end

    // MDU sequencer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= 6'd0;
            mdu_op_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mdu_op_q <= mdu_op_d;
        end
    end

    // Output mapping; mdu_op already shows the new operation in its start cycle.
    always_comb begin
        stall       = stall_s;
        pc_en       = ~stall_s;
        if_id_en    = ~stall_s;
        id_ex_flush = stall_s;
        mdu_start   = start_s;
        mdu_op      = mdu_op_d;
        mdu_busy    = (count_q != 6'd0);
        mdu_done    = (count_q == 6'd1);
    end

endmodule
